// File: rtl/wb_sram_target.sv
// rtl/wb_sram_target.sv - Wishbone B4 SRAM target with registered feedback bursts
// Optional out-of-range ERR termination: WB_SRAM_TARGET_ERR_EN
module wb_sram_target #(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter int                       MEM_ADDR_BITS = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE     = '0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [WB_ADDR_WIDTH-1:0]   ADR,
    input  logic [2:0]                 CTI,
    input  logic [1:0]                 BTE,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
    input  logic [WB_DATA_WIDTH/8-1:0] SEL,
    input  logic                       CYC,
    input  logic                       STB,
    input  logic                       WE,
    output logic [WB_DATA_WIDTH-1:0]   DAT_R,
    output logic                       ACK,
    output logic                       ERR
);

    localparam int NB    = WB_DATA_WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int SPAN  = MEM_ADDR_BITS + LB;
    localparam int DEPTH = 1 << MEM_ADDR_BITS;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESP,
        S_BURST
    } state_t;

    logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

    state_t                   state_q, state_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic                     oor_q, oor_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [WB_DATA_WIDTH-1:0] dat_r_q;

    logic [WB_ADDR_WIDTH-1:0] off;
    logic [MEM_ADDR_BITS-1:0] req_word;
    logic                     req_oor;
    logic [MEM_ADDR_BITS-1:0] addr_inc, wrap_mask, next_addr;
    logic                     next_oor;
    logic                     load_rd, clr_dat, wr_en;
    logic [MEM_ADDR_BITS-1:0] rd_addr;
    logic                     req;
    logic                     unused_off;

    assign off        = ADR - ADDR_BASE;
    assign req_word   = off[LB +: MEM_ADDR_BITS];
    assign unused_off = ^off;
    assign req        = CYC & STB;

`ifdef WB_SRAM_TARGET_ERR_EN
    generate
        if (SPAN >= WB_ADDR_WIDTH) begin : g_full_span
            assign req_oor = 1'b0;
        end else begin : g_span_chk
            assign req_oor = |(off >> SPAN);
        end
    endgenerate
`else
    assign req_oor = 1'b0;
`endif

    // Wrap modes only cycle the low bits; linear carries through the whole counter
    always_comb begin
        addr_inc = addr_q + 1'b1;
        case (BTE)
            2'b01:   wrap_mask = MEM_ADDR_BITS'(3);
            2'b10:   wrap_mask = MEM_ADDR_BITS'(7);
            2'b11:   wrap_mask = MEM_ADDR_BITS'(15);
            default: wrap_mask = '0;
        endcase
        if (BTE == 2'b00) begin
            next_addr = addr_inc;
        end else begin
            next_addr = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
        end
`ifdef WB_SRAM_TARGET_ERR_EN
        next_oor = oor_q | ((BTE == 2'b00) & (&addr_q));
`else
        next_oor = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        oor_d   = oor_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        load_rd = 1'b0;
        clr_dat = 1'b0;
        wr_en   = 1'b0;
        rd_addr = addr_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = req_word;
                    oor_d   = req_oor;
                    ack_d   = ~req_oor;
                    err_d   = req_oor;
                    state_d = (CTI == CTI_INCR) ? S_BURST : S_RESP;
                    rd_addr = req_word;
                    clr_dat = req_oor;
                    load_rd = ~WE & ~req_oor;
                end
            end
            S_RESP: begin
                wr_en   = WE & req & ~oor_q;
                state_d = S_IDLE;
            end
            S_BURST: begin
                if (req && (CTI == CTI_INCR || CTI == CTI_EOB)) begin
                    wr_en = WE & ~oor_q;
                    if (CTI == CTI_INCR) begin
                        addr_d  = next_addr;
                        oor_d   = next_oor;
                        ack_d   = ~next_oor;
                        err_d   = next_oor;
                        rd_addr = next_addr;
                        clr_dat = next_oor;
                        load_rd = ~next_oor;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            oor_q   <= oor_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            if (load_rd) begin
                dat_r_q <= mem[rd_addr];
            end else if (clr_dat) begin
                dat_r_q <= '0;
            end
        end
    end

    // Read above samples the pre-write word, so same-cycle read-during-write sees old data
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (SEL[b]) begin
                    mem[addr_q][b*8 +: 8] <= DAT_W[b*8 +: 8];
                end
            end
        end
    end

    assign DAT_R = dat_r_q;
    assign ACK   = ack_q;
    assign ERR   = err_q;

endmodule
